// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU/CSR results (valid/ready, buffered in a small FIFO)
// and load responses (no backpressure) onto one registered register-file write port.
module writeback_unit #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_alu_valid,
  output logic                   o_alu_ready,
  input  logic [RF_ADDR_LEN-1:0] i_alu_rd_addr,
  input  logic [RF_DATA_LEN-1:0] i_alu_data,
  input  logic                   i_ld_valid,
  input  logic [RF_ADDR_LEN-1:0] i_ld_rd_addr,
  input  logic [2:0]             i_ld_funct3,
  input  logic [1:0]             i_ld_byte_off,
  input  logic [RF_DATA_LEN-1:0] i_ld_rdata,
  output logic                   o_rf_w_en,
  output logic [RF_ADDR_LEN-1:0] o_rf_rd_addr,
  output logic [RF_DATA_LEN-1:0] o_rf_rd_write_data,
  output logic                   o_fwd_valid,
  output logic [RF_ADDR_LEN-1:0] o_fwd_addr,
  output logic [RF_DATA_LEN-1:0] o_fwd_data,
  output logic                   o_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [RF_ADDR_LEN-1:0] r_mem_addr [FIFO_DEPTH];
  logic [RF_DATA_LEN-1:0] r_mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0]       r_count;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;

  logic                   r_w_en;
  logic [RF_ADDR_LEN-1:0] r_rd_addr;
  logic [RF_DATA_LEN-1:0] r_rd_data;

  logic                   w_fifo_empty;
  logic                   w_alu_fire;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_sel_valid;
  logic [RF_ADDR_LEN-1:0] w_sel_addr;
  logic [RF_DATA_LEN-1:0] w_sel_data;
  logic [7:0]             w_ld_byte;
  logic [15:0]            w_ld_half;
  logic [RF_DATA_LEN-1:0] w_ld_data;

  assign w_fifo_empty = (r_count == '0);
  assign o_alu_ready  = (r_count < DEPTH_C);
  assign w_alu_fire   = i_alu_valid && o_alu_ready;
  // ALU results queue behind a load or behind older buffered results to keep ALU order.
  assign w_push       = w_alu_fire && (i_ld_valid || !w_fifo_empty);
  assign w_pop        = !i_ld_valid && !w_fifo_empty;

  always_comb begin
    w_ld_byte = i_ld_rdata[{i_ld_byte_off, 3'b000} +: 8];
    w_ld_half = i_ld_byte_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_funct3)
      3'b000:  w_ld_data = {{(RF_DATA_LEN-8){w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{(RF_DATA_LEN-16){w_ld_half[15]}}, w_ld_half};
      3'b010:  w_ld_data = i_ld_rdata;
      3'b100:  w_ld_data = {{(RF_DATA_LEN-8){1'b0}}, w_ld_byte};
      3'b101:  w_ld_data = {{(RF_DATA_LEN-16){1'b0}}, w_ld_half};
      default: w_ld_data = '0;
    endcase
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    if (i_ld_valid) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = i_ld_rd_addr;
      w_sel_data  = w_ld_data;
    end else if (!w_fifo_empty) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = r_mem_addr[r_rptr];
      w_sel_data  = r_mem_data[r_rptr];
    end else if (i_alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = i_alu_rd_addr;
      w_sel_data  = i_alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_mem_addr[r_wptr] <= i_alu_rd_addr;
        r_mem_data[r_wptr] <= i_alu_data;
        r_wptr             <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  // x0 results are consumed but never written; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_en    <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else if (w_sel_valid) begin
      r_w_en    <= (w_sel_addr != '0);
      r_rd_addr <= w_sel_addr;
      r_rd_data <= w_sel_data;
    end else begin
      r_w_en    <= 1'b0;
    end
  end

  assign o_rf_w_en          = r_w_en;
  assign o_rf_rd_addr       = r_rd_addr;
  assign o_rf_rd_write_data = r_rd_data;
  assign o_fwd_valid        = r_w_en;
  assign o_fwd_addr         = r_rd_addr;
  assign o_fwd_data         = r_rd_data;
  assign o_busy             = !w_fifo_empty || r_w_en;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_writeback_unit;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_rd_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_rd_addr = '0;
  logic [2:0]    ld_funct3 = '0;
  logic [1:0]    ld_byte_off = '0;
  logic [DW-1:0] ld_rdata = '0;
  logic          rf_w_en;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_write_data;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  writeback_unit #(.RF_ADDR_LEN(AW), .RF_DATA_LEN(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready),
    .i_alu_rd_addr(alu_rd_addr), .i_alu_data(alu_data),
    .i_ld_valid(ld_valid), .i_ld_rd_addr(ld_rd_addr), .i_ld_funct3(ld_funct3),
    .i_ld_byte_off(ld_byte_off), .i_ld_rdata(ld_rdata),
    .o_rf_w_en(rf_w_en), .o_rf_rd_addr(rf_rd_addr), .o_rf_rd_write_data(rf_rd_write_data),
    .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  function automatic logic [DW-1:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [DW-1:0] word);
    int unsigned b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd1: return (h >= 32768) ? h - 65536 : h;
      3'd2: return word;
      3'd4: return b;
      3'd5: return h;
      default: return 0;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL reset_w_en got %0b want 0", rf_w_en); end
    n_cmp++; if (rf_rd_addr !== '0) begin n_err++; $display("FAIL reset_addr got %0d want 0", rf_rd_addr); end
    n_cmp++; if (rf_rd_write_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", rf_rd_write_data); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", alu_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    // queue two ALU results behind loads, then reset mid-operation
    ld_valid = 1'b1; ld_rd_addr = 5'd7; ld_funct3 = 3'b010; ld_rdata = 32'h1;
    alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_data = 32'h11;
    tick();
    alu_rd_addr = 5'd2; alu_data = 32'h22;
    tick();
    idle_inputs();
    n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_fill_ready got %0b want 0", alu_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL reset_mid_w_en got %0b want 0", rf_w_en); end
    tick();
    n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL reset_discard_w_en got %0b want 0", rf_w_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_discard_busy got %0b want 0", busy); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_discard_ready got %0b want 1", alu_ready); end
  endtask

  task automatic test_single_alu;
    alu_valid = 1'b1; alu_rd_addr = 5'd5; alu_data = 32'hDEADBEEF;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %0b want 1", alu_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (rf_w_en !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_write_data !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL single_write got en=%0b x%0d=%h want en=1 x5=deadbeef", rf_w_en, rf_rd_addr, rf_rd_write_data); end
    n_cmp++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd5 || fwd_data !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL single_fwd got v=%0b x%0d=%h want v=1 x5=deadbeef", fwd_valid, fwd_addr, fwd_data); end
    tick();
    n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL single_once got %0b want 0", rf_w_en); end
    n_cmp++; if (rf_rd_addr !== 5'd5 || rf_rd_write_data !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL single_hold got x%0d=%h want x5=deadbeef", rf_rd_addr, rf_rd_write_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %0b want 0", busy); end
  endtask

  task automatic test_ld_and_alu;
    ld_valid = 1'b1; ld_rd_addr = 5'd3; ld_funct3 = 3'b010; ld_byte_off = 2'd1; ld_rdata = 32'h12345678;
    alu_valid = 1'b1; alu_rd_addr = 5'd4; alu_data = 32'hA5;
    tick();
    idle_inputs();
    n_cmp++; if (rf_w_en !== 1'b1 || rf_rd_addr !== 5'd3 || rf_rd_write_data !== 32'h12345678)
      begin n_err++; $display("FAIL ldalu_first got en=%0b x%0d=%h want x3=12345678", rf_w_en, rf_rd_addr, rf_rd_write_data); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ldalu_busy got %0b want 1", busy); end
    tick();
    n_cmp++; if (rf_w_en !== 1'b1 || rf_rd_addr !== 5'd4 || rf_rd_write_data !== 32'hA5)
      begin n_err++; $display("FAIL ldalu_second got en=%0b x%0d=%h want x4=a5", rf_w_en, rf_rd_addr, rf_rd_write_data); end
    tick();
    n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL ldalu_done got %0b want 0", rf_w_en); end
  endtask

  task automatic test_load_extract;
    logic [2:0]    f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]    off [5] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd0};
    logic [DW-1:0] exp [5] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h0};
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_rd_addr = 5'd10 + AW'(i); ld_funct3 = f3[i]; ld_byte_off = off[i];
      ld_rdata = 32'h80FF7F01;
      tick();
      idle_inputs();
      n_cmp++; if (rf_w_en !== 1'b1 || rf_rd_addr !== 5'd10 + AW'(i) || rf_rd_write_data !== exp[i])
        begin n_err++; $display("FAIL extract_%0d got en=%0b x%0d=%h want x%0d=%h", i, rf_w_en, rf_rd_addr, rf_rd_write_data, 10 + i, exp[i]); end
    end
    tick();
  endtask

  task automatic test_starvation;
    int acc = 0;
    logic [AW-1:0] exp_addr [7] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd1, 5'd2, 5'd3};
    for (int cyc = 0; cyc < 8; cyc++) begin
      logic took;
      ld_valid = (cyc < 4); ld_rd_addr = 5'd20 + AW'(cyc); ld_funct3 = 3'b010; ld_rdata = 32'(cyc);
      alu_valid = (acc < 3); alu_rd_addr = AW'(acc + 1); alu_data = 32'(100 + acc);
      if (cyc == 2) begin
        n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_ready got %0b want 0", alu_ready); end
      end
      took = alu_valid && alu_ready;
      tick();
      if (took) acc++;
      if (cyc < 7) begin
        n_cmp++; if (rf_w_en !== 1'b1 || rf_rd_addr !== exp_addr[cyc])
          begin n_err++; $display("FAIL starve_write_%0d got en=%0b x%0d want en=1 x%0d", cyc, rf_w_en, rf_rd_addr, exp_addr[cyc]); end
      end else begin
        n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL starve_end got %0b want 0", rf_w_en); end
      end
      if (cyc == 4) begin
        n_cmp++; if (rf_rd_write_data !== 32'd100) begin n_err++; $display("FAIL starve_x1_data got %h want 64", rf_rd_write_data); end
      end
    end
    idle_inputs();
    n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL starve_accepts got %0d want 3", acc); end
  endtask

  task automatic test_x0;
    alu_valid = 1'b1; alu_rd_addr = 5'd0; alu_data = 32'h55;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %0b want 1", alu_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL x0_w_en got %0b want 0", rf_w_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL x0_busy got %0b want 0", busy); end
    tick();
  endtask

  task automatic test_random;
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    rst = 1'b1; idle_inputs(); tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic          exp_ready, sel, exp_en, had_entries;
      logic [AW-1:0] s_addr;
      logic [DW-1:0] s_data;
      ld_valid    = ($urandom_range(0, 99) < 40);
      ld_rd_addr  = AW'($urandom_range(0, 31));
      ld_funct3   = 3'($urandom_range(0, 7));
      ld_byte_off = 2'($urandom_range(0, 3));
      ld_rdata    = $urandom;
      alu_valid   = ($urandom_range(0, 99) < 60);
      alu_rd_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      alu_data    = $urandom;
      exp_ready   = (q_addr.size() < DEPTH);
      n_cmp++; if (alu_ready !== exp_ready)
        begin n_err++; $display("FAIL rand_ready_%0d got %0b want %0b", cyc, alu_ready, exp_ready); end
      had_entries = (q_addr.size() != 0);
      sel = 1'b0; s_addr = '0; s_data = '0;
      if (ld_valid) begin
        sel = 1'b1; s_addr = ld_rd_addr; s_data = ref_load(ld_funct3, ld_byte_off, ld_rdata);
      end else if (had_entries) begin
        sel = 1'b1; s_addr = q_addr.pop_front(); s_data = q_data.pop_front();
      end else if (alu_valid) begin
        sel = 1'b1; s_addr = alu_rd_addr; s_data = alu_data;
      end
      if (alu_valid && exp_ready && (ld_valid || had_entries)) begin
        q_addr.push_back(alu_rd_addr); q_data.push_back(alu_data);
      end
      exp_en = sel && (s_addr != 0);
      tick();
      n_cmp++; if (rf_w_en !== exp_en)
        begin n_err++; $display("FAIL rand_w_en_%0d got %0b want %0b", cyc, rf_w_en, exp_en); end
      if (exp_en) begin
        n_cmp++; if (rf_rd_addr !== s_addr || rf_rd_write_data !== s_data)
          begin n_err++; $display("FAIL rand_write_%0d got x%0d=%h want x%0d=%h", cyc, rf_rd_addr, rf_rd_write_data, s_addr, s_data); end
      end
      n_cmp++; if (busy !== ((q_addr.size() != 0) || exp_en))
        begin n_err++; $display("FAIL rand_busy_%0d got %0b want %0b", cyc, busy, (q_addr.size() != 0) || exp_en); end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_ld_and_alu();
    test_load_extract();
    test_starvation();
    test_x0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
